// File: rtl/predictor_phase_sequencer.sv
// Phase sequencer for the predictor datapath: one-hot phase triggers, one-phase-early
// lead enables, programmable dwell per phase, stall hold, and frame bookkeeping.
module predictor_phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int DWELL_W    = 4,
  parameter int COUNT_W    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  stall,
  output logic [NUM_PHASES-1:0] trigger,
  output logic [NUM_PHASES-1:0] enable,
  output logic                  busy,
  output logic                  frame_done,
  output logic [COUNT_W-1:0]    frame_count
);

  localparam int PH_W = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [DWELL_W-1:0]      cnt_q, cnt_d;
  logic [DWELL_W-1:0]      dwell_lat_q, dwell_lat_d;
  logic                    cont_q, cont_d;
  logic                    stop_pend_q, stop_pend_d;
  logic [NUM_PHASES-1:0]   trigger_q, trigger_d;
  logic [NUM_PHASES-1:0]   enable_q, enable_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;
  logic [COUNT_W-1:0]      frame_count_q, frame_count_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      cnt_q         <= '0;
      dwell_lat_q   <= '0;
      cont_q        <= 1'b0;
      stop_pend_q   <= 1'b0;
      trigger_q     <= '0;
      enable_q      <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      dwell_lat_q   <= dwell_lat_d;
      cont_q        <= cont_d;
      stop_pend_q   <= stop_pend_d;
      trigger_q     <= trigger_d;
      enable_q      <= enable_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    dwell_lat_d   = dwell_lat_q;
    cont_d        = cont_q;
    stop_pend_d   = stop_pend_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          state_d     = S_RUN;
          phase_d     = '0;
          cnt_d       = '0;
          dwell_lat_d = dwell;
          cont_d      = continuous;
        end
      end
      S_RUN, S_HOLD: begin
        stop_pend_d = stop_pend_q | stop;
        // Leaving HOLD with stall low performs the same step RUN would, so the
        // stalled cycles add exactly one clock each to the frame.
        if (stall) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_RUN;
          if (cnt_q == dwell_lat_q) begin
            cnt_d = '0;
            if (phase_q == LAST_PH) begin
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + COUNT_W'(1);
              phase_d       = '0;
              if (cont_q && !(stop_pend_q | stop)) begin
                dwell_lat_d = dwell;
              end else begin
                state_d     = S_IDLE;
                stop_pend_d = 1'b0;
              end
            end else begin
              phase_d = phase_q + PH_W'(1);
            end
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    trigger_d = '0;
    if (busy_d) trigger_d = NUM_PHASES'(1) << phase_d;
    enable_d  = {trigger_d[NUM_PHASES-2:0], 1'b0};
  end

  assign trigger     = trigger_q;
  assign enable      = enable_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_predictor_phase_sequencer.sv
// Directed bench for predictor_phase_sequencer: default build plus a 2-bit counter
// build and a 6-phase build, all driven from the same stimulus.
module tb_predictor_phase_sequencer;

  logic       clock = 1'b0;
  logic       reset, start, stop, continuous, stall;
  logic [3:0] dwell;

  logic [3:0]  trigger, enable;
  logic        busy, frame_done;
  logic [15:0] frame_count;

  logic [3:0]  c2_trigger, c2_enable;
  logic        c2_busy, c2_frame_done;
  logic [1:0]  c2_frame_count;

  logic [5:0]  p6_trigger, p6_enable;
  logic        p6_busy, p6_frame_done;
  logic [15:0] p6_frame_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  predictor_phase_sequencer u_dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .continuous(continuous), .dwell(dwell), .stall(stall),
    .trigger(trigger), .enable(enable), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  predictor_phase_sequencer #(.COUNT_W(2)) u_c2 (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .continuous(continuous), .dwell(dwell), .stall(stall),
    .trigger(c2_trigger), .enable(c2_enable), .busy(c2_busy),
    .frame_done(c2_frame_done), .frame_count(c2_frame_count)
  );

  predictor_phase_sequencer #(.NUM_PHASES(6)) u_p6 (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .continuous(continuous), .dwell(dwell), .stall(stall),
    .trigger(p6_trigger), .enable(p6_enable), .busy(p6_busy),
    .frame_done(p6_frame_done), .frame_count(p6_frame_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e_trig, input logic [31:0] e_en,
                            input logic [31:0] e_busy, input logic [31:0] e_fd,
                            input logic [31:0] e_cnt);
    check_val({tag, ".trigger"},     32'(trigger),     e_trig);
    check_val({tag, ".enable"},      32'(enable),      e_en);
    check_val({tag, ".busy"},        32'(busy),        e_busy);
    check_val({tag, ".frame_done"},  32'(frame_done),  e_fd);
    check_val({tag, ".frame_count"}, 32'(frame_count), e_cnt);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] exp_en4(input int p);
    return (p < 3) ? (32'd1 << (p + 1)) : 32'd0;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; dwell = 4'd0; stall = 1'b0;
    tick(); tick();
    check_outs("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Continuous, dwell 0, then reset in phase 2 of the fourth frame
    start = 1'b1; continuous = 1'b1; dwell = 4'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) tick();
      check_outs("cont", 32'd1 << (i % 4), exp_en4(i % 4), 1,
                 ((i >= 4) && (i % 4 == 0)) ? 1 : 0, i / 4);
    end
    reset = 1'b1;
    tick();
    check_outs("midreset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Stop pulse in phase 1 of the third frame
    start = 1'b1; continuous = 1'b1; dwell = 4'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      if (i == 10) stop = 1'b0;
      check_outs("stoprun", 32'd1 << (i % 4), exp_en4(i % 4), 1,
                 ((i >= 4) && (i % 4 == 0)) ? 1 : 0, i / 4);
      if (i == 9) stop = 1'b1;
    end
    tick();
    check_outs("stopend", 0, 0, 0, 1, 3);
    tick();
    check_outs("stopidle", 0, 0, 0, 0, 3);

    // Single-shot, dwell 2; mid-frame dwell change must be ignored
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1; continuous = 1'b0; dwell = 4'd2;
    tick();
    start = 1'b0; dwell = 4'd0;
    for (int j = 0; j < 12; j++) begin
      if (j > 0) tick();
      check_outs("single", 32'd1 << (j / 3), exp_en4(j / 3), 1, 0, 0);
    end
    tick();
    check_outs("singleend", 0, 0, 0, 1, 1);
    tick();
    check_outs("singleidle", 0, 0, 0, 0, 1);

    // Start held high across a single-shot frame end
    start = 1'b1; continuous = 1'b0; dwell = 4'd0;
    tick();
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      check_outs("held", 32'd1 << j, exp_en4(j), 1, 0, 1);
    end
    tick();
    check_outs("heldidle", 0, 0, 0, 1, 2);
    tick();
    check_outs("heldrestart", 1, 2, 1, 0, 2);
    start = 1'b0;
    tick(); tick(); tick();
    check_outs("heldlast", 8, 0, 1, 0, 2);
    tick();
    check_outs("heldend", 0, 0, 0, 1, 3);

    // Stall for 5 cycles in phase 1, with a stop recorded during the stall
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1; continuous = 1'b1; dwell = 4'd0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      logic [31:0] et;
      if (c > 0) tick();
      if (c == 4) stop = 1'b0;
      if (c == 6) stall = 1'b0;
      et = (c == 0) ? 32'd1 : (c <= 6) ? 32'd2 : (c == 7) ? 32'd4 : (c == 8) ? 32'd8 : 32'd0;
      check_outs("stall", et, (c == 9) ? 32'd0 : {et[30:0], 1'b0} & 32'hF,
                 (c < 9) ? 1 : 0, (c == 9) ? 1 : 0, (c == 9) ? 1 : 0);
      if (c == 1) stall = 1'b1;
      if (c == 3) stop = 1'b1;
    end

    // Counter wrap on the 2-bit build and the 6-phase one-hot sequence
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1; continuous = 1'b1; dwell = 4'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 21; i++) begin
      if (i > 0) tick();
      check_val("c2.frame_count", 32'(c2_frame_count), (i / 4) % 4);
      check_val("p6.trigger", 32'(p6_trigger), 32'd1 << (i % 6));
      check_val("p6.enable", 32'(p6_enable), (i % 6 < 5) ? (32'd1 << (i % 6 + 1)) : 32'd0);
      check_val("p6.frame_done", 32'(p6_frame_done), ((i > 0) && (i % 6 == 0)) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
